// File: rtl/vga_frame_writer_pkg.sv
// Shared types for the VGA frame writer path.
// Writer state enum, pixel/word widths, default frame size.
package vga_pkg;

  localparam int PIXEL_W = 16;
  localparam int WORD_W = 32;
  localparam int DEFAULT_FRAME_WORDS = 19200;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    WAIT_SOF,
    LOW,
    HIGH
  } wr_state_e;

endpackage

// File: rtl/vga_frame_writer_if.sv
// RGB565 pixel stream with valid/ready handshake and SOF marker.
// master drives tdata/tvalid/tuser, slave returns tready.
interface vga_frame_writer_if;
  import vga_pkg::*;

  pixel_t s_tdata;
  logic   s_tvalid;
  logic   s_tuser;
  logic   s_tready;

  modport master (
    output s_tdata, s_tvalid, s_tuser,
    input  s_tready
  );

  modport slave (
    input  s_tdata, s_tvalid, s_tuser,
    output s_tready
  );

endinterface

// File: rtl/vga_frame_writer.sv
// Packs pixel pairs {odd, even} into 32-bit words for the frame BRAM.
// Ports: clk, reset (async low), enable, stream s, BRAM write port, status.
module vga_frame_writer
  import vga_pkg::*;
#(
  parameter int unsigned FRAME_WORDS = DEFAULT_FRAME_WORDS,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  vga_frame_writer_if.slave     s,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [WORD_W-1:0]     bram_dout,
  output logic [3:0]            bram_we,
  output logic                  bram_en,
  output logic                  frame_done,
  output logic [7:0]            sof_err_cnt,
  output logic                  busy
);

  localparam int IDX_W =
    (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(FRAME_WORDS - 1);

  wr_state_e             state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  pixel_t                lower_q, lower_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_W-1:0]     dout_q, dout_d;
  logic                  we_q, we_d;
  logic                  done_q, done_d;
  logic [7:0]            err_q, err_d;
  logic                  beat;

  assign s.s_tready = enable & reset;
  assign beat = s.s_tvalid & s.s_tready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lower_d = lower_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    if (beat && s.s_tuser) begin
      // SOF always restarts; mid-frame it drops the pending pixel
      if (state_q != WAIT_SOF && err_q != 8'hFF)
        err_d = err_q + 8'd1;
      lower_d = s.s_tdata;
      idx_d   = '0;
      state_d = HIGH;
    end else if (beat) begin
      unique case (state_q)
        WAIT_SOF: ;
        LOW: begin
          lower_d = s.s_tdata;
          state_d = HIGH;
        end
        HIGH: begin
          addr_d = BASE_ADDR
                 + (ADDR_WIDTH'(idx_q) << 2);
          dout_d = {s.s_tdata, lower_q};
          we_d   = 1'b1;
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            idx_d   = '0;
            state_d = WAIT_SOF;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = LOW;
          end
        end
        default: state_d = WAIT_SOF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= WAIT_SOF;
      idx_q   <= '0;
      lower_q <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lower_q <= lower_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bram_addr   = addr_q;
  assign bram_dout   = dout_q;
  assign bram_we     = {4{we_q}};
  assign bram_en     = we_q;
  assign frame_done  = done_q;
  assign sof_err_cnt = err_q;
  assign busy        = (state_q != WAIT_SOF);

endmodule

// File: doc/vga_frame_writer.md
Name: vga_frame_writer

Overview:
- Upstream stage of the VGA display path: accepts a 16-bit RGB565 pixel stream, packs pixel pairs into 32-bit words and writes them into write port A of the frame BRAM (sdp_bwe_bram).
- The VGA controller reads the same BRAM on port B.
- Word i holds {pixel 2i+1, pixel 2i}, at byte address BASE_ADDR + 4*i.
- A full frame is FRAME_WORDS words.

Parameters:
- FRAME_WORDS, 19200, words per frame (2*FRAME_WORDS pixels).
- BASE_ADDR, 0, byte address of word 0.
- ADDR_WIDTH, 32, width of bram_addr.

Ports:
- clk  in  1  system clock, shared with both BRAM ports and VGA.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  when low, stream is stalled (s_tready=0).
- s_tdata  in  16  pixel, RGB565.
- s_tvalid  in  1  pixel valid.
- s_tuser  in  1  start-of-frame marker on pixel 0.
- s_tready  out  1  pixel accepted when s_tvalid & s_tready.
- bram_addr  out  ADDR_WIDTH  byte write address.
- bram_dout  out  32  packed word {odd, even}.
- bram_we  out  4  byte write enables; 4'b1111 on write, else 0.
- bram_en  out  1  port enable; equals |bram_we.
- frame_done  out  1  one-cycle pulse with last word write of a frame.
- sof_err_cnt  out  8  saturating count of premature SOFs.
- busy  out  1  high while a frame is in progress (state != WAIT_SOF).

Behaviour:
- Reset (async assert, sync release): all outputs 0 except s_tready=0; state WAIT_SOF; word_idx=0; pending pixel cleared.
- s_tready = enable while not in reset (no internal backpressure; BRAM always accepts).
- "Beat" = s_tvalid & s_tready on a rising edge.
- State WAIT_SOF:
  - beat with s_tuser=1 -> store pixel as lower half, word_idx=0, go HIGH.
  - beat with s_tuser=0 -> pixel discarded, no write.
- State LOW (expecting even pixel):
  - beat, tuser=0 -> store lower, go HIGH.
- State HIGH (expecting odd pixel):
  - beat, tuser=0 -> register write: bram_addr=BASE_ADDR+4*word_idx, bram_dout={s_tdata, lower}, bram_we=4'b1111, bram_en=1.
  - Write outputs are valid the cycle after the beat (1-cycle latency). bram_we/bram_en pulse for exactly one cycle per word.
  - If word_idx==FRAME_WORDS-1: frame_done=1 in the same cycle as that write, word_idx->0, go WAIT_SOF.
  - Else: word_idx+1, go LOW.
- Premature SOF (beat with tuser=1 in LOW or HIGH):
  - sof_err_cnt+1, saturating at 255.
  - Any pending lower pixel is discarded with no write.
  - Current pixel becomes pixel 0 of a new frame: lower=pixel, word_idx=0, go HIGH.
- Back-to-back frames: SOF beat in the cycle right after the last pixel is accepted normally; no idle cycle needed.
- Valid gaps and enable low: state, pending pixel and word_idx hold; write outputs idle (we=0).
- word_idx width = $clog2(FRAME_WORDS); address = BASE_ADDR + (word_idx << 2), zero-extended to ADDR_WIDTH.
- Reset mid-frame: write outputs clear immediately. After release, the block waits for SOF; a partial frame is not resumed.

Decomposition:
- Shared package vga_pkg holds:
  - typedef enum {WAIT_SOF, LOW, HIGH} for the writer state.
  - constants PIXEL_W=16, WORD_W=32, DEFAULT_FRAME_WORDS=19200.
  - typedef pixel_t (16b).
- No sub-module. One sequential FSM/datapath process plus a combinational s_tready assign.

Test Plan:
1. Reset, then stream SOF + pixels 0..38399 continuously -> 19200 writes; word i at addr 4i = {2i+1, 2i}; BRAM readback matches; frame_done exactly once, on the write to addr 76796; sof_err_cnt=0.
2. 5 pixels with tuser=0, then SOF frame starting 0xA000 -> no writes before SOF; first write addr 0, data 0xA001A000.
3. tvalid randomly toggled, enable low for 10 cycles mid-frame -> s_tready=0 and no writes while enable low; final BRAM contents identical to test 1.
4. SOF reasserted on pixel 101 (pending lower = pixel 100), value 0x1234, next pixel 0x5678 -> no write of word 50; sof_err_cnt=1; next write addr 0, data 0x56781234.
5. reset asserted asynchronously after word 500 written -> bram_we/bram_en/frame_done drop to 0 without waiting for a clock edge; after release, non-SOF pixels ignored until a new SOF restarts at addr 0.
6. Two frames back-to-back, second SOF the cycle after the first frame's last pixel -> frame_done pulses twice; second frame overwrites from addr 0; no pixel dropped.
